// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: state codes, opcode
// constants and the datapath select encodings driven by the FSM.
package multicycle_control_unit_pkg;

    localparam int STATE_W = 4;

    // FSM state codes
    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXECR  = 4'd6;
    localparam logic [3:0] ST_EXECI  = 4'd7;
    localparam logic [3:0] ST_ALUWB  = 4'd8;
    localparam logic [3:0] ST_BEQ    = 4'd9;
    localparam logic [3:0] ST_JAL    = 4'd10;
    localparam logic [3:0] ST_TRAP   = 4'd11;

    // Opcodes recognised in DECODE
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    // Write-back result select
    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    // True for states that hold a memory request open
    function automatic logic is_mem_state(input logic [3:0] st);
        return (st == ST_FETCH) || (st == ST_MEMRD) || (st == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mcu_wait_timer.sv
// Memory wait counter with timeout compare. Counts cycles a memory request
// is outstanding without mem_ready; timeout flags when the count reaches
// MAX_WAIT so the FSM can trap on a still-unanswered request.
module mcu_wait_timer #(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    logic [WAIT_W-1:0] count_r;

    // Wait count: cleared on reset or state entry, advanced while stalled
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_r <= {WAIT_W{1'b0}};
        end else if (inc) begin
            count_r <= count_r + WAIT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign timeout = (count_r == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-style control FSM with memory wait timeout trap and a
// retired-instruction counter. Optional JAL handling is enabled by defining
// JAL_SUPPORT_EN; without it the JAL opcode traps like any illegal opcode.
module multicycle_control_unit #(
    parameter int OPC_W    = 7,
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             trap,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);
    import multicycle_control_unit_pkg::*;

    logic [STATE_W-1:0] state_r, next_s;
    logic [CNT_W-1:0]   retired_r;
    logic               timeout_s, retire_s;
    logic               mem_req_s, mem_we_s, adr_src_s, ir_write_s;
    logic               pc_write_s, reg_write_s;
    logic [1:0]         alu_src_a_s, alu_src_b_s, alu_op_s, result_src_s;

    mcu_wait_timer #(.WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (next_s != state_r),
        .inc     (mem_req_s & ~mem_ready),
        .timeout (timeout_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            retired_r <= retired_r + CNT_W'(1);
        end else begin
            retired_r <= retired_r;
        end
    end

    // Next-state logic; mem_ready wins over timeout on the last wait cycle
    always_comb begin
        next_s = ST_TRAP;
        case (state_r)
            ST_FETCH, ST_MEMRD, ST_MEMWR: begin
                if (mem_ready) begin
                    if (state_r == ST_FETCH)      next_s = ST_DECODE;
                    else if (state_r == ST_MEMRD) next_s = ST_MEMWB;
                    else                          next_s = ST_FETCH;
                end else if (timeout_s) begin
                    next_s = ST_TRAP;
                end else begin
                    next_s = state_r;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OPC_W'(OP_LW), OPC_W'(OP_SW): next_s = ST_MEMADR;
                    OPC_W'(OP_RTYPE):             next_s = ST_EXECR;
                    OPC_W'(OP_ITYPE):             next_s = ST_EXECI;
                    OPC_W'(OP_BEQ):               next_s = ST_BEQ;
`ifdef JAL_SUPPORT_EN
                    OPC_W'(OP_JAL):               next_s = ST_JAL;
`endif
                    default:                      next_s = ST_TRAP;
                endcase
            end
            ST_MEMADR: begin
                if (opcode == OPC_W'(OP_LW)) begin
                    next_s = ST_MEMRD;
                end else if (opcode == OPC_W'(OP_SW)) begin
                    next_s = ST_MEMWR;
                end else begin
                    next_s = ST_TRAP;
                end
            end
            ST_EXECR, ST_EXECI:          next_s = ST_ALUWB;
            ST_MEMWB, ST_ALUWB, ST_BEQ:  next_s = ST_FETCH;
`ifdef JAL_SUPPORT_EN
            ST_JAL:                      next_s = ST_FETCH;
`endif
            ST_TRAP:                     next_s = ST_TRAP;
            default:                     next_s = ST_TRAP;
        endcase
    end

    // State-decoded control outputs and retire strobe
    always_comb begin
        mem_req_s    = is_mem_state(state_r);
        mem_we_s     = 1'b0;
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_RS2;
        alu_op_s     = ALUOP_ADD;
        result_src_s = RES_ALUOUT;
        retire_s     = 1'b0;
        case (state_r)
            ST_FETCH: begin
                ir_write_s   = mem_ready;
                pc_write_s   = mem_ready;
                alu_src_b_s  = mem_ready ? SRCB_FOUR : SRCB_RS2;
                result_src_s = mem_ready ? RES_ALU : RES_ALUOUT;
            end
            ST_DECODE: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_IMM;
            end
            ST_MEMADR, ST_EXECI: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
            end
            ST_MEMRD: adr_src_s = 1'b1;
            ST_MEMWB: begin
                reg_write_s  = 1'b1;
                result_src_s = RES_MEM;
                retire_s     = 1'b1;
            end
            ST_MEMWR: begin
                mem_we_s  = 1'b1;
                adr_src_s = 1'b1;
                retire_s  = mem_ready;
            end
            ST_EXECR: begin
                alu_src_a_s = SRCA_RS1;
                alu_op_s    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
            end
            ST_BEQ: begin
                alu_src_a_s = SRCA_RS1;
                alu_op_s    = ALUOP_SUB;
                pc_write_s  = zero;
                retire_s    = 1'b1;
            end
`ifdef JAL_SUPPORT_EN
            ST_JAL: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_FOUR;
                reg_write_s = 1'b1;
                pc_write_s  = 1'b1;
                retire_s    = 1'b1;
            end
`endif
            default: begin
                retire_s = 1'b0;
            end
        endcase
    end

    // All outputs read zero while reset is asserted
    assign mem_req    = ~reset & mem_req_s;
    assign mem_we     = ~reset & mem_we_s;
    assign adr_src    = ~reset & adr_src_s;
    assign ir_write   = ~reset & ir_write_s;
    assign pc_write   = ~reset & pc_write_s;
    assign reg_write  = ~reset & reg_write_s;
    assign alu_src_a  = reset ? 2'b00 : alu_src_a_s;
    assign alu_src_b  = reset ? 2'b00 : alu_src_b_s;
    assign alu_op     = reset ? 2'b00 : alu_op_s;
    assign result_src = reset ? 2'b00 : result_src_s;
    assign trap       = ~reset & (state_r == ST_TRAP);
    assign busy       = ~reset & (state_r != ST_FETCH);
    assign retired    = reset ? {CNT_W{1'b0}} : retired_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: each driven cycle pushes the
// expected output vector, which is popped and compared at the falling edge.
module tb_multicycle_control_unit;

    localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3,
                   S_MEMRD = 4, S_MEMWB = 5, S_MEMWR = 6, S_EXECR = 7,
                   S_EXECI = 8, S_ALUWB = 9, S_BEQ = 10, S_JAL = 11, S_TRAP = 12;

    logic        clk, reset, zero, mem_ready;
    logic [6:0]  opcode;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, trap, busy;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [31:0] retired;

    logic [47:0] sb[$];
    logic [31:0] exp_ret;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    multicycle_control_unit #(.OPC_W(7), .WAIT_W(4), .MAX_WAIT(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .trap(trap), .busy(busy), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic string st_name(input int st);
        case (st)
            S_RST: return "reset";     S_FETCH: return "fetch";   S_DECODE: return "decode";
            S_MEMADR: return "memadr"; S_MEMRD: return "memrd";   S_MEMWB: return "memwb";
            S_MEMWR: return "memwr";   S_EXECR: return "execr";   S_EXECI: return "execi";
            S_ALUWB: return "aluwb";   S_BEQ: return "beq";       S_JAL: return "jal";
            default: return "trap";
        endcase
    endfunction

    // Expected {mem_req,mem_we,adr_src,ir_write,pc_write,reg_write,srca,srcb,aluop,res,trap,busy}
    function automatic logic [15:0] exp_ctrl(input int st, input logic rdy, input logic z);
        logic mr, we, as, ir, pw, rw, tr, bz;
        logic [1:0] sa, sbv, op, rs;
        {mr, we, as, ir, pw, rw, tr} = 7'b0;
        sa = 2'd0; sbv = 2'd0; op = 2'd0; rs = 2'd0;
        bz = (st != S_FETCH) && (st != S_RST);
        case (st)
            S_FETCH:  begin mr = 1'b1; ir = rdy; pw = rdy; sbv = rdy ? 2'd2 : 2'd0; rs = rdy ? 2'd2 : 2'd0; end
            S_DECODE: begin sa = 2'd1; sbv = 2'd1; end
            S_MEMADR: begin sa = 2'd2; sbv = 2'd1; end
            S_MEMRD:  begin mr = 1'b1; as = 1'b1; end
            S_MEMWB:  begin rw = 1'b1; rs = 2'd1; end
            S_MEMWR:  begin mr = 1'b1; we = 1'b1; as = 1'b1; end
            S_EXECR:  begin sa = 2'd2; op = 2'b10; end
            S_EXECI:  begin sa = 2'd2; sbv = 2'd1; end
            S_ALUWB:  begin rw = 1'b1; end
            S_BEQ:    begin sa = 2'd2; op = 2'b01; pw = z; end
            S_JAL:    begin sa = 2'd1; sbv = 2'd2; rw = 1'b1; pw = 1'b1; end
            S_TRAP:   begin tr = 1'b1; end
            default:  begin bz = 1'b0; end
        endcase
        return {mr, we, as, ir, pw, rw, sa, sbv, op, rs, tr, bz};
    endfunction

    task automatic step(input int st, input logic rdy, input logic z);
        logic [47:0] got_v, exp_v;
        mem_ready = rdy;
        zero = z;
        sb.push_back({exp_ctrl(st, rdy, z), exp_ret});
        @(negedge clk);
        got_v = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, alu_op, result_src, trap, busy, retired};
        check_eq("sb_depth", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            check_eq($sformatf("%s@%0d", st_name(st), cyc), 64'(got_v), 64'(exp_v));
        end
        if (st == S_MEMWB || st == S_ALUWB || st == S_BEQ || st == S_JAL || (st == S_MEMWR && rdy))
            exp_ret = exp_ret + 32'd1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_ret = 32'd0;
        step(S_RST, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic fetch(input int waits);
        for (int i = 0; i < waits; i++) step(S_FETCH, 1'b0, 1'b0);
        step(S_FETCH, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = 7'd0; exp_ret = 32'd0;
        do_reset();
        do_reset();

        // add: four cycles, write-back only in ALUWB
        opcode = 7'b0110011;
        fetch(0); step(S_DECODE, 1'b0, 1'b0); step(S_EXECR, 1'b0, 1'b0); step(S_ALUWB, 1'b0, 1'b0);

        // lw with mem_ready delayed three cycles in MEMRD
        opcode = 7'b0000011;
        fetch(0); step(S_DECODE, 1'b0, 1'b0); step(S_MEMADR, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(S_MEMRD, 1'b0, 1'b0);
        step(S_MEMRD, 1'b1, 1'b0); step(S_MEMWB, 1'b0, 1'b0);

        // sw with fetch and store stalls
        opcode = 7'b0100011;
        fetch(2); step(S_DECODE, 1'b0, 1'b0); step(S_MEMADR, 1'b0, 1'b0);
        step(S_MEMWR, 1'b0, 1'b0); step(S_MEMWR, 1'b1, 1'b0);

        // addi
        opcode = 7'b0010011;
        fetch(0); step(S_DECODE, 1'b0, 1'b0); step(S_EXECI, 1'b0, 1'b0); step(S_ALUWB, 1'b0, 1'b0);

        // beq taken then not taken
        opcode = 7'b1100011;
        fetch(0); step(S_DECODE, 1'b0, 1'b0); step(S_BEQ, 1'b0, 1'b1);
        fetch(0); step(S_DECODE, 1'b0, 1'b0); step(S_BEQ, 1'b0, 1'b0);

        // mem_ready arriving exactly on the MAX_WAIT cycle completes normally
        opcode = 7'b0110011;
        fetch(15); step(S_DECODE, 1'b0, 1'b0); step(S_EXECR, 1'b0, 1'b0); step(S_ALUWB, 1'b0, 1'b0);

        // jal: handled only when the feature is built in
        opcode = 7'b1101111;
        fetch(0); step(S_DECODE, 1'b0, 1'b0);
`ifdef JAL_SUPPORT_EN
        step(S_JAL, 1'b0, 1'b0);
        fetch(0);
`else
        step(S_TRAP, 1'b0, 1'b0); step(S_TRAP, 1'b1, 1'b0);
`endif
        do_reset();

        // illegal opcode traps, retired frozen, reset recovers
        opcode = 7'b1111111;
        fetch(0); step(S_DECODE, 1'b0, 1'b0);
        step(S_TRAP, 1'b0, 1'b0); step(S_TRAP, 1'b1, 1'b1); step(S_TRAP, 1'b0, 1'b0);
        do_reset();
        opcode = 7'b0110011;
        fetch(0); step(S_DECODE, 1'b0, 1'b0); step(S_EXECR, 1'b0, 1'b0); step(S_ALUWB, 1'b0, 1'b0);

        // fetch timeout: 16 unanswered cycles trap
        fetch(0); step(S_DECODE, 1'b0, 1'b0); step(S_EXECR, 1'b0, 1'b0); step(S_ALUWB, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(S_FETCH, 1'b0, 1'b0);
        step(S_TRAP, 1'b0, 1'b0); step(S_TRAP, 1'b1, 1'b0);
        do_reset();

        // reset in the middle of a load wait clears the wait counter
        opcode = 7'b0000011;
        fetch(0); step(S_DECODE, 1'b0, 1'b0); step(S_MEMADR, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(S_MEMRD, 1'b0, 1'b0);
        do_reset();
        fetch(15); step(S_DECODE, 1'b0, 1'b0); step(S_MEMADR, 1'b0, 1'b0);
        step(S_MEMRD, 1'b1, 1'b0); step(S_MEMWB, 1'b0, 1'b0);
        fetch(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
